// File: rtl/hall_pkg.sv
// Shared definitions for the hall sensor decoder: code-to-sector table,
// invalid-sector marker, direction encodings and the modulo-6 sector delta.
package hall_pkg;

    localparam logic [2:0] SECTOR_INVALID = 3'b111;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    // {SA,SB,SC} -> sector; 000 and 111 never occur on a healthy sensor set
    function automatic logic [2:0] code2sector(input logic [2:0] code);
        case (code)
            3'b100:  return 3'd0;
            3'b110:  return 3'd1;
            3'b010:  return 3'd2;
            3'b011:  return 3'd3;
            3'b001:  return 3'd4;
            3'b101:  return 3'd5;
            default: return SECTOR_INVALID;
        endcase
    endfunction

    function automatic logic [2:0] sector_delta(input logic [2:0] old_s, input logic [2:0] new_s);
        logic [3:0] d;
        d = {1'b0, new_s} + 4'd6 - {1'b0, old_s};
        if (d >= 4'd6) begin
            d = d - 4'd6;
        end
        return d[2:0];
    endfunction

endpackage

// File: rtl/hall_sync_debounce.sv
// Two-flop synchronizer for the three hall lines plus an optional debounce
// filter (enabled by the HALL_DEBOUNCE_EN macro).
module hall_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_raw,
    output logic [2:0] o_code
);

    logic [2:0] r_sync1;
    logic [2:0] r_sync2;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("hall_sync_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef HALL_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [2:0]    r_cand;
    logic [2:0]    r_acc;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    // The count is the number of consecutive identical samples seen so far
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_sync2 != r_cand) begin
            w_cnt_next = CW'(1);
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cand <= 3'b000;
            r_acc  <= 3'b000;
            r_cnt  <= '0;
        end else begin
            r_cand <= r_sync2;
            r_cnt  <= w_cnt_next;
            if (w_cnt_next == CNT_MAX) begin
                r_acc <= r_sync2;
            end
        end
    end

    assign o_code = r_acc;
`else
    assign o_code = r_sync2;
`endif

endmodule

// File: rtl/hall_decoder.sv
// Hall sensor decoder: sector, direction, step pulse, position, period and
// stall tracking with a sticky fault. Debounce is enabled by HALL_DEBOUNCE_EN.
module hall_decoder
    import hall_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PERIOD_W        = 20,
    parameter int POS_W           = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    SA,
    input  logic                    SB,
    input  logic                    SC,
    input  logic                    clr_fault,
    output logic [2:0]              sector,
    output logic                    dir,
    output logic                    step,
    output logic signed [POS_W-1:0] position,
    output logic [PERIOD_W-1:0]     period,
    output logic                    period_valid,
    output logic                    stall,
    output logic                    fault
);

    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    logic [2:0]              w_code;
    logic [2:0]              w_new_sector;
    logic [2:0]              w_delta;
    logic                    w_legal, w_change, w_fwd, w_rev, w_skip, w_step_now, w_new_fault;

    logic [2:0]              r_code;
    logic [2:0]              r_sector;
    logic                    r_have;
    dir_e                    r_dir;
    logic                    r_step;
    logic signed [POS_W-1:0] r_pos;
    logic [PERIOD_W-1:0]     r_cnt;
    logic [PERIOD_W-1:0]     r_period;
    logic                    r_pvalid;
    logic                    r_stall;
    logic                    r_armed;
    logic                    r_fault;

    hall_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw ({SA, SB, SC}),
        .o_code(w_code)
    );

    // r_have marks that r_sector holds a legal reference for the delta
    always_comb begin
        w_new_sector = code2sector(w_code);
        w_legal      = (w_new_sector != SECTOR_INVALID);
        w_change     = (w_code != r_code);
        w_delta      = sector_delta(r_sector, w_new_sector);
        w_fwd        = w_change && w_legal && r_have && (w_delta == 3'd1);
        w_rev        = w_change && w_legal && r_have && (w_delta == 3'd5);
        w_skip       = w_change && w_legal && r_have && !(w_fwd || w_rev);
        w_step_now   = w_fwd || w_rev;
        w_new_fault  = w_skip || (w_change && !w_legal);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_code   <= 3'b000;
            r_sector <= SECTOR_INVALID;
            r_have   <= 1'b0;
            r_dir    <= DIR_FWD;
            r_step   <= 1'b0;
            r_pos    <= '0;
            r_cnt    <= CNT_MAX;
            r_period <= CNT_MAX;
            r_pvalid <= 1'b0;
            r_stall  <= 1'b1;
            r_armed  <= 1'b0;
            r_fault  <= 1'b1;
        end else begin
            r_code <= w_code;
            r_step <= w_step_now;

            if (w_change) begin
                r_sector <= w_new_sector;
                r_have   <= w_legal;
            end

            if (w_fwd) begin
                r_dir <= DIR_FWD;
                r_pos <= r_pos + POS_W'(1);
            end else if (w_rev) begin
                r_dir <= DIR_REV;
                r_pos <= r_pos - POS_W'(1);
            end

            // The first step after reset or stall only starts the measurement
            if (w_step_now) begin
                r_cnt   <= '0;
                r_stall <= 1'b0;
                r_armed <= 1'b1;
                if (r_armed) begin
                    r_period <= (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + PERIOD_W'(1);
                    r_pvalid <= 1'b1;
                end
            end else if (r_cnt == CNT_MAX) begin
                r_stall  <= 1'b1;
                r_period <= CNT_MAX;
                r_pvalid <= 1'b0;
                r_armed  <= 1'b0;
            end else begin
                r_cnt <= r_cnt + PERIOD_W'(1);
            end

            if (w_new_fault) begin
                r_fault <= 1'b0;
            end else if (clr_fault && w_legal) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign sector       = r_sector;
    assign dir          = r_dir;
    assign step         = r_step;
    assign position     = r_pos;
    assign period       = r_period;
    assign period_valid = r_pvalid;
    assign stall        = r_stall;
    assign fault        = r_fault;

endmodule

// File: tb/tb_hall_decoder.sv
// Directed bench for hall_decoder: wide instance for rotation/period checks,
// narrow instance (PERIOD_W=8, POS_W=3) for stall and position wrap.
module tb_hall_decoder;

`ifdef HALL_DEBOUNCE_EN
    localparam int LAT = 3 + 16;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] hall = 3'b000;
    logic       clr_fault = 1'b0;

    logic [2:0]         sector_a, sector_b;
    logic               dir_a, dir_b, step_a, step_b;
    logic signed [15:0] pos_a;
    logic signed [2:0]  pos_b;
    logic [19:0]        period_a;
    logic [7:0]         period_b;
    logic               pvalid_a, pvalid_b, stall_a, stall_b, fault_a, fault_b;

    int n_chk = 0;
    int n_err = 0;
    int n_step_a = 0;

    always #5 clk = ~clk;

    hall_decoder #(.DEBOUNCE_CYCLES(16), .PERIOD_W(20), .POS_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .SA(hall[2]), .SB(hall[1]), .SC(hall[0]),
        .clr_fault(clr_fault), .sector(sector_a), .dir(dir_a), .step(step_a),
        .position(pos_a), .period(period_a), .period_valid(pvalid_a),
        .stall(stall_a), .fault(fault_a)
    );

    hall_decoder #(.DEBOUNCE_CYCLES(16), .PERIOD_W(8), .POS_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .SA(hall[2]), .SB(hall[1]), .SC(hall[0]),
        .clr_fault(clr_fault), .sector(sector_b), .dir(dir_b), .step(step_b),
        .position(pos_b), .period(period_b), .period_valid(pvalid_b),
        .stall(stall_b), .fault(fault_b)
    );

    always @(negedge clk) begin
        if (step_a) n_step_a++;
    end

    typedef struct {
        logic [2:0] code;
        int         hold;
        int         exp_sector;
        int         exp_pos;
        int         exp_dir;
    } vec_t;

    vec_t fwd_tab[7];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int cyc;
        bit seen;

        fwd_tab[0] = '{3'b100, 1000, 0, 0, 0};
        fwd_tab[1] = '{3'b110, 1000, 1, 1, 0};
        fwd_tab[2] = '{3'b010, 1000, 2, 2, 0};
        fwd_tab[3] = '{3'b011, 1000, 3, 3, 0};
        fwd_tab[4] = '{3'b001, 1000, 4, 4, 0};
        fwd_tab[5] = '{3'b101, 1000, 5, 5, 0};
        fwd_tab[6] = '{3'b100, 1000, 0, 6, 0};

        tick(1);
        do_reset();
        chk("rst_sector", int'(sector_a), 7);
        chk("rst_dir", int'(dir_a), 0);
        chk("rst_step", int'(step_a), 0);
        chk("rst_position", int'(pos_a), 0);
        chk("rst_period", int'(period_a), 20'hFFFFF);
        chk("rst_period_valid", int'(pvalid_a), 0);
        chk("rst_stall", int'(stall_a), 1);
        chk("rst_fault", int'(fault_a), 1);

        // Forward rotation, one full electrical turn
        base = n_step_a;
        for (int i = 0; i < 7; i++) begin
            hall = fwd_tab[i].code;
            tick(fwd_tab[i].hold);
            chk($sformatf("fwd%0d_sector", i), int'(sector_a), fwd_tab[i].exp_sector);
            chk($sformatf("fwd%0d_position", i), int'(pos_a), fwd_tab[i].exp_pos);
            chk($sformatf("fwd%0d_dir", i), int'(dir_a), fwd_tab[i].exp_dir);
            chk($sformatf("fwd%0d_fault", i), int'(fault_a), 1);
        end
        chk("fwd_steps", n_step_a - base, 6);
        chk("fwd_period", int'(period_a), 1000);
        chk("fwd_period_valid", int'(pvalid_a), 1);
        chk("wrap_position_b", int'(pos_b), -2);

        // Reverse rotation from a fresh reset
        do_reset();
        base = n_step_a;
        hall = 3'b100; tick(500);
        hall = 3'b101; tick(500);
        hall = 3'b001; tick(500);
        chk("rev_steps", n_step_a - base, 2);
        chk("rev_dir", int'(dir_a), 1);
        chk("rev_position", int'(pos_a), -2);
        chk("rev_period", int'(period_a), 500);
        chk("rev_period_valid", int'(pvalid_a), 1);
        chk("rev_sector", int'(sector_a), 4);

        // Skipped sector, clear, illegal code, recovery
        do_reset();
        base = n_step_a;
        hall = 3'b100; tick(50);
        hall = 3'b010; tick(50);
        chk("skip_fault", int'(fault_a), 0);
        chk("skip_sector", int'(sector_a), 2);
        chk("skip_steps", n_step_a - base, 0);
        chk("skip_position", int'(pos_a), 0);
        clr_fault = 1'b1; tick(1);
        clr_fault = 1'b0; tick(1);
        chk("clr_fault", int'(fault_a), 1);
        hall = 3'b000; tick(50);
        chk("illegal_sector", int'(sector_a), 7);
        chk("illegal_fault", int'(fault_a), 0);
        clr_fault = 1'b1; tick(1);
        clr_fault = 1'b0; tick(1);
        chk("illegal_clr_ignored", int'(fault_a), 0);
        hall = 3'b110; tick(50);
        chk("reload_sector", int'(sector_a), 1);
        chk("reload_steps", n_step_a - base, 0);

        // Latency from raw edge to step, and single-cycle pulse
        do_reset();
        hall = 3'b100; tick(100);
        hall = 3'b110;
        cyc = 0;
        seen = 1'b0;
        for (int i = 1; i <= LAT + 10; i++) begin
            tick(1);
            if (step_a && !seen) begin
                seen = 1'b1;
                cyc = i;
                break;
            end
        end
        chk("latency", cyc, LAT);
        tick(1);
        chk("step_one_cycle", int'(step_a), 0);

`ifdef HALL_DEBOUNCE_EN
        // Short glitch is filtered out
        do_reset();
        base = n_step_a;
        hall = 3'b100; tick(100);
        hall = 3'b110; tick(10);
        hall = 3'b100; tick(100);
        chk("glitch_steps", n_step_a - base, 0);
        chk("glitch_sector", int'(sector_a), 0);
`endif

        // Stall on the narrow-period instance
        do_reset();
        hall = 3'b100; tick(100);
        hall = 3'b110; tick(LAT + 2);
        chk("b_first_step_stall", int'(stall_b), 0);
        tick(300);
        chk("b_stall", int'(stall_b), 1);
        chk("b_stall_period_valid", int'(pvalid_b), 0);
        chk("b_stall_period", int'(period_b), 255);
        hall = 3'b010; tick(LAT + 2);
        chk("b_stall_cleared", int'(stall_b), 0);
        chk("b_after_stall_valid", int'(pvalid_b), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hall_decoder.md
HALL_DECODER -- requirements
Module: hall_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive identical synchronized samples needed to accept a new hall code (>=1).
REQ-002 Parameter PERIOD_W, default 20: width of the commutation period counter and output.
REQ-003 Parameter POS_W, default 16: width of the signed sector position counter.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk is the single clock and rst_n is the synchronous active-low reset.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 SA, SB, SC  input  1 each  raw hall sensor lines, asynchronous to clk.
REQ-008 clr_fault  input  1  single-cycle request to clear the latched fault.
REQ-009 sector  output  3  decoded sector 0..5; 3'b111 means no valid code yet, or the code is illegal.
REQ-010 dir  output  1  last observed rotation direction: 0 = forward (increasing sector), 1 = reverse.
REQ-011 step  output  1  one-cycle pulse on each accepted adjacent sector transition.
REQ-012 position  output  POS_W  signed count of accepted steps: +1 forward, -1 reverse.
REQ-013 period  output  PERIOD_W  clk cycles between the last two accepted steps.
REQ-014 period_valid  output  1  high once period holds a real measurement.
REQ-015 stall  output  1  high when no step has occurred for 2^PERIOD_W-1 cycles.
REQ-016 fault  output  1  active-low fault flag; 0 = illegal code or skipped sector seen.

Function
REQ-017 The block SHALL pass SA, SB, SC through a 2-flop synchronizer before any use.
REQ-018 Code-to-sector mapping on {SA,SB,SC} SHALL be: 100->0, 110->1, 010->2, 011->3, 001->4, 101->5; codes 000 and 111 are illegal.
REQ-019 An accepted code change with delta = (new-old) mod 6 SHALL be handled as follows:
- delta 1: forward step; dir<=0; position+1.
- delta 5: reverse step; dir<=1; position-1.
- delta 2, 3 or 4: skip; fault<=0; sector updated; no step; position and period unchanged.
REQ-020 The first legal code after reset, or after an illegal code, SHALL only load sector; no step, no dir change, no period update.
REQ-021 step SHALL assert in the cycle after the accepted code register updates: total latency 3 + DEBOUNCE_CYCLES clk cycles from raw input edge to step (with HALL_DEBOUNCE_EN).
REQ-022 A free-running counter SHALL increment every cycle and saturate at all-ones. On a step:
- period <= counter+1;
- counter <= 0;
- period_valid <= 1 (from the second step after reset or stall; the first step only restarts the counter).
REQ-023 When the counter saturates, the block SHALL set stall=1, period<=all-ones and period_valid<=0; the next step clears stall and restarts the counter.
REQ-024 position SHALL wrap in two's complement at its limits.
REQ-025 While the accepted code is illegal: sector=3'b111, fault=0, no step.
REQ-026 fault SHALL be sticky: it returns to 1 only on clr_fault while the accepted code is legal. If clr_fault and a new fault occur in the same cycle, the new fault wins.

Reset
REQ-027 On rst_n=0 at a clock edge, outputs SHALL reset to: sector=3'b111, dir=0, step=0, position=0, period=all-ones, period_valid=0, stall=1, fault=1.
REQ-028 Reset SHALL also clear the synchronizer, debounce counter and first-code flag; reset mid-rotation discards all history.

Configuration
REQ-029 Macro HALL_DEBOUNCE_EN, when defined: a new synchronized code SHALL be accepted only after DEBOUNCE_CYCLES consecutive identical samples; any differing sample restarts the count.
REQ-030 When HALL_DEBOUNCE_EN is not defined: the synchronized code SHALL be accepted directly; latency is 3 cycles; DEBOUNCE_CYCLES is ignored.

Structure
REQ-031 A shared package hall_pkg SHALL hold the code-to-sector table, SECTOR_INVALID = 3'b111, and the direction encodings (DIR_FWD = 0, DIR_REV = 1).
REQ-032 The synchronizer and debounce logic SHALL be one sub-module, hall_sync_debounce, operating on 3 bits.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset, then code 100 held: sector=0, fault=1, no step, position=0.
- Sequence 100,110,010,011,001,101,100, each held 1000 cycles: 6 steps, dir=0, position=+6, period=1000, period_valid=1.
- Reverse sequence 100,101,001, each held 500 cycles: 2 steps, dir=1, position=-2, period=500.
- Jump 100->010: fault=0, no step, sector=2. Then clr_fault: fault=1. Then 000: sector=7, fault=0.
- With HALL_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle glitch 100->110->100 gives no step and no sector change. Code held past the stall limit (PERIOD_W=8, i.e. 255 cycles): stall=1 and period_valid=0; the next step clears stall.
